mux_rr_nx1: RTL and testbench

- Parametrised, registered N-to-1 multiplexer with per-channel valid/ready handshake and a global enable.
- Two selection modes:
  - Fixed-select: the channel is chosen by `sel`.
  - Round-robin: the block arbitrates fairly among requesting channels.
- Output is registered with a one-entry holding stage. It sits between N producer channels and a single downstream consumer.
- Replaces combinational Nx1 muxes wherever sources are bursty or the consumer can stall.

---
 rtl/mux_rr_nx1.sv | 105 ++++++++++
 tb/tb_mux_rr_nx1.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nx1.sv
// rtl/mux_rr_nx1.sv - registered N-to-1 mux with fixed-select or round-robin arbitration
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        enable; 0 blocks new grants (a held word still drains)
//   mode      0 = fixed select via sel, 1 = round-robin
//   sel       channel index used in mode 0 (values >= N never grant)
//   in_valid  per-channel request, bit i = channel i
//   in_data   packed channel data, channel i at [i*W +: W]
//   in_ready  per-channel accept, one-hot or zero
//   out_valid output register holds a word
//   out_data  registered selected data
//   out_sel   channel index that produced out_data
//   out_ready consumer accepts the output word
module mux_rr_nx1 #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_sel,
    input  logic            out_ready
);

    localparam logic [SW:0] LP_N = (SW+1)'(N);

    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic [SW-1:0]   r_out_sel;
    logic [SW-1:0]   r_ptr;

    logic            w_space;
    logic            w_fix_ok;
    logic            w_rr_found;
    logic [SW-1:0]   w_rr_idx;
    logic [SW:0]     w_sum;
    logic            w_grant;
    logic [SW-1:0]   w_g;
    logic [SW-1:0]   w_ptr_next;

    // The slot is free when empty or when the held word leaves this cycle,
    // which allows back-to-back pass-through.
    assign w_space  = !r_out_valid || out_ready;

    assign w_fix_ok = ({1'b0, sel} < LP_N) ? in_valid[sel] : 1'b0;

    // Rotating priority scan starting at r_ptr; the first requester wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_sum      = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (SW+1)'(k);
            if (w_sum >= LP_N) begin
                w_sum = w_sum - LP_N;
            end
            if (!w_rr_found && in_valid[w_sum[SW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_sum[SW-1:0];
            end
        end
    end

    // rst_n gates the grant so in_ready is silent while reset is held.
    assign w_grant    = rst_n && en && w_space && (mode ? w_rr_found : w_fix_ok);
    assign w_g        = mode ? w_rr_idx : sel;
    assign w_ptr_next = (w_g == SW'(N-1)) ? '0 : w_g + 1'b1;

    assign in_ready   = w_grant ? ({{(N-1){1'b0}}, 1'b1} << w_g) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[w_g*W +: W];
                r_out_sel   <= w_g;
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// tb/tb_mux_rr_nx1.sv - self-checking bench for mux_rr_nx1 against a behavioural model
module tb_mux_rr_nx1;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready;

    int checks   = 0;
    int failures = 0;

    // Model of the output slot and arbitration pointer.
    int m_valid = 0;
    int m_data  = 0;
    int m_sel   = 0;
    int m_ptr   = 0;

    mux_rr_nx1 #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which channel the rules grant right now, or -1 for none.
    function automatic int model_grant();
        int idx;
        if (!en) return -1;
        if (m_valid != 0 && !out_ready) return -1;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    // One clock: check in_ready before the edge, update the model, check outputs after.
    task automatic cycle();
        int g;
        logic [N-1:0] er;
        #1;
        g  = model_grant();
        er = (g >= 0) ? N'(1 << g) : '0;
        chk("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1;
            m_data  = int'(in_data[g*W +: W]);
            m_sel   = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_sel",   32'(out_sel),   32'(m_sel));
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = 4'b1111;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1'b1;
        model_reset();

        // Reset state with requests present
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_sel",   32'(out_sel),   0);
        chk("rst_in_ready",  32'(in_ready),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed select stepped over every channel
        for (int s = 0; s < N; s++) begin
            sel = SW'(s);
            for (int c = 0; c < 10; c++) begin
                cycle();
                if (c == 0) begin
                    chk("m0_data", 32'(out_data), 32'(8'h11 * (s + 1)));
                    chk("m0_sel",  32'(out_sel),  32'(s));
                end
            end
        end

        // Round-robin, all requesting: ascending and gapless
        mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_seq",   32'(out_sel),   32'(k % N));
            chk("rr_valid", 32'(out_valid), 1);
        end

        // Sparse requesters alternate, then a single one every cycle
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_sparse", 32'(out_sel), (k % 2 == 0) ? 1 : 3);
        end
        in_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("rr_single", 32'(out_sel), 1);
        end

        // Backpressure holding 22, then same-cycle reload
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b1111;
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_data",  32'(out_data), 32'h22);
            chk("stall_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        sel       = 2'd2;
        cycle();
        chk("reload_valid", 32'(out_valid), 1);
        chk("reload_data",  32'(out_data),  32'h33);

        // Disable with a pending word: it drains, nothing new loads
        out_ready = 1'b0;
        cycle();
        en        = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("en0_drain", 32'(out_valid), 0);
        cycle();
        chk("en0_ready", 32'(in_ready), 0);
        chk("en0_idle",  32'(out_valid), 0);
        en = 1'b1;
        cycle();
        chk("en1_load", 32'(out_valid), 1);

        // Fixed select pointing at an idle channel
        sel      = 2'd3;
        in_valid = 4'b0111;
        cycle();
        cycle();
        chk("idle_sel_valid", 32'(out_valid), 0);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            en        = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel       = SW'($urandom);
            in_valid  = N'($urandom);
            in_data   = (N*W)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Asynchronous reset mid-stream
        en        = 1'b1;
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready = 1'b0;
        cycle();
        cycle();
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data",  32'(out_data),  0);
        chk("arst_out_sel",   32'(out_sel),   0);
        chk("arst_in_ready",  32'(in_ready),  0);
        @(negedge clk);
        rst_n     = 1'b1;
        mode      = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("post_rst_first", 32'(out_sel), 0);
        cycle();
        chk("post_rst_second", 32'(out_sel), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
